// File: rtl/capture_buffer_if.sv
// Host-facing signal bundle for capture_buffer: sample input, trigger/arm
// controls, readback address and status outputs.
interface capture_buffer_if #(
  parameter int DEPTH_LOG2 = 10,
  parameter int DATA_W     = 16
);
  logic signed [DATA_W-1:0] InData;
  logic                     ExtTrig;
  logic                     ForceTrig;
  logic                     Arm;
  logic [DEPTH_LOG2-1:0]    PreTrig;
  logic [15:0]              Decim;
  logic [DEPTH_LOG2-1:0]    RdAddr;
  logic signed [DATA_W-1:0] RdData;
  logic [2:0]               State;
  logic                     Done;
  logic [DEPTH_LOG2:0]      Count;

  modport master (
    output InData, ExtTrig, ForceTrig, Arm, PreTrig, Decim, RdAddr,
    input  RdData, State, Done, Count
  );

  modport slave (
    input  InData, ExtTrig, ForceTrig, Arm, PreTrig, Decim, RdAddr,
    output RdData, State, Done, Count
  );
endinterface

// File: rtl/capture_buffer.sv
// Triggered sample recorder: circular RAM with pre-trigger depth and
// decimation, read back by logical index once the capture is done.
module capture_buffer #(
  parameter int DEPTH_LOG2 = 10,
  parameter int DATA_W     = 16
) (
  input logic             Clk,
  input logic             Reset,
  capture_buffer_if.slave cap
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PREFILL   = 3'd1,
    WAIT_TRIG = 3'd2,
    POST      = 3'd3,
    DONE      = 3'd4
  } state_t;

  state_t                   state_q, state_d;
  logic                     arm_q, ext_q, force_q;
  logic                     arm_edge, trig, strobe;
  logic [15:0]              dcnt;
  logic [DEPTH_LOG2-1:0]    wr_ptr, start_addr, rd_addr_q, start_next;
  logic [DEPTH_LOG2:0]      count, post_target;
  logic signed [DATA_W-1:0] rd_q;
  logic                     we, cnt_inc, load_start, restart;

  logic signed [DATA_W-1:0] mem [DEPTH];

  assign arm_edge    = cap.Arm & ~arm_q;
  assign trig        = (cap.ExtTrig & ~ext_q) | (cap.ForceTrig & ~force_q);
  assign strobe      = (dcnt == cap.Decim);
  assign post_target = DEPTH_CNT - {1'b0, cap.PreTrig};
  // Start address must include a sample written on the trigger cycle itself.
  assign start_next  = (we ? wr_ptr + 1'b1 : wr_ptr) - cap.PreTrig;

  always_comb begin
    state_d    = state_q;
    we         = 1'b0;
    cnt_inc    = 1'b0;
    load_start = 1'b0;
    restart    = 1'b0;
    if (arm_edge) begin
      state_d = PREFILL;
      restart = 1'b1;
    end else begin
      case (state_q)
        IDLE: ;
        // wr_ptr starts at zero after arming, so it doubles as the prefill count.
        PREFILL: begin
          if (wr_ptr == cap.PreTrig) state_d = WAIT_TRIG;
          else if (strobe)           we      = 1'b1;
        end
        WAIT_TRIG: begin
          we = strobe;
          if (trig) begin
            state_d    = POST;
            load_start = 1'b1;
          end
        end
        POST: begin
          if (strobe) begin
            we      = 1'b1;
            cnt_inc = 1'b1;
            if (count + 1'b1 == post_target) state_d = DONE;
          end
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q    <= IDLE;
      arm_q      <= 1'b1;
      ext_q      <= 1'b1;
      force_q    <= 1'b1;
      dcnt       <= '0;
      wr_ptr     <= '0;
      start_addr <= '0;
      count      <= '0;
      rd_addr_q  <= '0;
      rd_q       <= '0;
    end else begin
      state_q   <= state_d;
      arm_q     <= cap.Arm;
      ext_q     <= cap.ExtTrig;
      force_q   <= cap.ForceTrig;
      dcnt      <= (arm_edge || strobe) ? 16'd0 : dcnt + 1'b1;
      if (restart)  wr_ptr <= '0;
      else if (we)  wr_ptr <= wr_ptr + 1'b1;
      if (restart)      count <= '0;
      else if (cnt_inc) count <= count + 1'b1;
      if (load_start) start_addr <= start_next;
      rd_addr_q <= start_addr + cap.RdAddr;
      rd_q      <= mem[rd_addr_q];
    end
  end

  always_ff @(posedge Clk) begin
    if (we) mem[wr_ptr] <= cap.InData;
  end

  assign cap.RdData = rd_q;
  assign cap.State  = state_q;
  assign cap.Done   = (state_q == DONE);
  assign cap.Count  = count;
endmodule

// File: tb/tb_capture_buffer.sv
// Self-checking bench for capture_buffer: ramp-based vector table, randomized
// captures against a sample-history model, and hand-written corner sequences.
module tb_capture_buffer;
  localparam int DL    = 4;
  localparam int DEPTH = 1 << DL;

  logic clk = 1'b0;
  logic rst_n;
  int   passed = 0;
  int   total  = 0;

  logic signed [15:0] hist [$];
  logic signed [15:0] expv [DEPTH];

  capture_buffer_if #(.DEPTH_LOG2(DL), .DATA_W(16)) cap ();
  capture_buffer #(.DEPTH_LOG2(DL), .DATA_W(16)) dut (.Clk(clk), .Reset(rst_n), .cap(cap));

  always #5 clk = ~clk;

  typedef struct {
    int pt;
    int d;
    int rd0;
    int cnt;
  } vec_t;

  function automatic void check(input string nm, input logic signed [31:0] act,
                                input logic signed [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Arms at cycle 0, triggers at cycle trig_j; strobes fall on cycles j>0 with
  // j % (d+1) == 0. Runs until all post-trigger samples are strobed.
  task automatic do_capture(input int pt, input int d, input bit frc, input bit ramp,
                            input int trig_j, output int tidx);
    int j;
    int guard;
    hist.delete();
    cap.PreTrig = DL'(pt); cap.Decim = 16'(d);
    cap.Arm = 1'b0; cap.ExtTrig = 1'b0; cap.ForceTrig = 1'b0; cap.RdAddr = '0;
    cyc(); cyc();
    cap.Arm = 1'b1;
    cap.InData = ramp ? 16'sd60 : 16'($urandom);
    cyc();
    cap.Arm = 1'b0;
    for (j = 1; j <= trig_j; j++) begin
      cap.InData = ramp ? 16'(60 + j) : 16'($urandom);
      if (j == trig_j) begin
        if (frc) cap.ForceTrig = 1'b1;
        else     cap.ExtTrig   = 1'b1;
      end
      cyc();
      if (j % (d + 1) == 0) hist.push_back(cap.InData);
    end
    j = trig_j;
    tidx = hist.size();
    cap.ExtTrig = 1'b0; cap.ForceTrig = 1'b0;
    guard = 0;
    while (hist.size() < tidx + DEPTH - pt && guard < 2000) begin
      j++;
      cap.InData = ramp ? 16'(60 + j) : 16'($urandom);
      cyc();
      if (j % (d + 1) == 0) hist.push_back(cap.InData);
      guard++;
    end
    check("cap_done", cap.Done, 1);
    check("cap_count", cap.Count, DEPTH - pt);
  endtask

  // Pipelined readback: a new address every cycle, data checked two edges later.
  task automatic readback(input string tag);
    for (int k = 0; k <= DEPTH; k++) begin
      if (k < DEPTH) cap.RdAddr = DL'(k);
      cyc();
      if (k >= 1) check($sformatf("%s_rd%0d", tag, k - 1), cap.RdData, expv[k - 1]);
    end
  endtask

  task automatic wait_done(input string nm);
    int g = 0;
    while (!cap.Done && g < 500) begin
      cyc();
      g++;
    end
    check(nm, cap.Done, 1);
  endtask

  vec_t vecs [4];

  initial begin
    int tidx;
    int g;
    vecs[0] = '{pt: 4, d: 0, rd0: 97,  cnt: 12};
    vecs[1] = '{pt: 0, d: 0, rd0: 101, cnt: 16};
    vecs[2] = '{pt: 4, d: 3, rd0: 88,  cnt: 12};
    vecs[3] = '{pt: 8, d: 1, rd0: 86,  cnt: 8};

    // Inputs held high through reset must not look like edges.
    rst_n = 1'b0;
    cap.InData = '0; cap.Arm = 1'b1; cap.ExtTrig = 1'b1; cap.ForceTrig = 1'b1;
    cap.PreTrig = '0; cap.Decim = '0; cap.RdAddr = '0;
    repeat (3) cyc();
    check("rst_state", cap.State, 0);
    check("rst_done", cap.Done, 0);
    check("rst_count", cap.Count, 0);
    check("rst_rddata", cap.RdData, 0);
    rst_n = 1'b1;
    repeat (5) cyc();
    check("held_state", cap.State, 0);
    check("held_done", cap.Done, 0);

    // Ramp vectors: arm at InData=60, ExtTrig rises on InData=100.
    foreach (vecs[i]) begin
      do_capture(vecs[i].pt, vecs[i].d, 1'b0, 1'b1, 40, tidx);
      check($sformatf("vec%0d_count", i), cap.Count, vecs[i].cnt);
      for (int a = 0; a < DEPTH; a++) expv[a] = 16'(vecs[i].rd0 + a * (vecs[i].d + 1));
      readback($sformatf("vec%0d", i));
    end

    // Randomized captures against the sample-history model.
    for (int r = 0; r < 6; r++) begin
      int d, pt, tj;
      bit frc;
      d   = int'($urandom_range(0, 3));
      pt  = int'($urandom_range(0, DEPTH - 1));
      frc = 1'($urandom_range(0, 1));
      tj  = (2 * pt + 3) * (d + 1) + int'($urandom_range(0, 20));
      do_capture(pt, d, frc, 1'b0, tj, tidx);
      for (int a = 0; a < DEPTH; a++) expv[a] = hist[tidx - pt + a];
      readback($sformatf("rnd%0d", r));
    end

    // Triggers during PREFILL are discarded; a later one works.
    cap.PreTrig = DL'(8); cap.Decim = 16'd3; cap.Arm = 1'b0; cap.ExtTrig = 1'b0;
    cyc();
    cap.Arm = 1'b1; cyc(); cap.Arm = 1'b0;
    cyc(); cyc();
    cap.ExtTrig = 1'b1; cyc(); cap.ExtTrig = 1'b0; cyc();
    check("pf_state", cap.State, 1);
    g = 0;
    while (cap.State != 3'd2 && g < 200) begin cyc(); g++; end
    check("pf_wait_state", cap.State, 2);
    repeat (3) cyc();
    cap.ExtTrig = 1'b1; cyc(); cap.ExtTrig = 1'b0;
    check("pf_post_state", cap.State, 3);
    wait_done("pf_done");
    check("pf_count", cap.Count, 8);

    // Re-arm in the middle of POST restarts the capture.
    cap.PreTrig = DL'(4); cap.Decim = 16'd0;
    cap.Arm = 1'b1; cyc(); cap.Arm = 1'b0;
    repeat (20) cyc();
    cap.ExtTrig = 1'b1; cyc(); cap.ExtTrig = 1'b0;
    g = 0;
    while (cap.Count != 5'd5 && g < 100) begin cyc(); g++; end
    check("rearm_pre_count", cap.Count, 5);
    cap.Arm = 1'b1; cyc(); cap.Arm = 1'b0;
    check("rearm_state", cap.State, 1);
    check("rearm_count", cap.Count, 0);
    check("rearm_done", cap.Done, 0);
    repeat (20) cyc();
    cap.ExtTrig = 1'b1; cyc(); cap.ExtTrig = 1'b0;
    wait_done("rearm_done2");
    check("rearm_count2", cap.Count, 12);

    // Reset during POST.
    cap.Arm = 1'b1; cyc(); cap.Arm = 1'b0;
    repeat (20) cyc();
    cap.ExtTrig = 1'b1; cyc(); cap.ExtTrig = 1'b0;
    repeat (3) cyc();
    check("mid_post_state", cap.State, 3);
    rst_n = 1'b0; cyc(); rst_n = 1'b1;
    check("midrst_state", cap.State, 0);
    check("midrst_done", cap.Done, 0);
    check("midrst_rddata", cap.RdData, 0);
    check("midrst_count", cap.Count, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/capture_buffer.md
Name: capture_buffer

Overview:
- Triggered sample recorder that feeds the host-readback side of a custom instrument.
- Stores one signed ADC stream into a circular block RAM, with a programmable pre-trigger depth and decimation.
- After capture, the host reads samples back by writing an index into a control register and reading the result from a status register.
- Complements the instrument's ADC-in / control-in path: this block is the data-out reader toward the host.

Parameters:
- DEPTH_LOG2, 10, log2 of buffer depth in samples (DEPTH = 2^DEPTH_LOG2).
- DATA_W, 16, sample width (signed).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-low reset.
- InData  in  DATA_W  signed sample; one sample offered every Clk.
- ExtTrig  in  1  external trigger; rising edge triggers.
- ForceTrig  in  1  software trigger (control bit); rising edge triggers.
- Arm  in  1  control bit; rising edge starts or restarts a capture.
- PreTrig  in  DEPTH_LOG2  pre-trigger sample count; 0 to DEPTH-1.
- Decim  in  16  store one sample every Decim+1 clocks.
- RdAddr  in  DEPTH_LOG2  logical read index; 0 = oldest sample of the capture.
- RdData  out  DATA_W  read sample; goes to a status register.
- State  out  3  FSM state code; goes to a status register.
- Done  out  1  capture complete.
- Count  out  DEPTH_LOG2+1  post-trigger samples written so far.

Behaviour:
Reset (Reset=0 at a Clk edge):
- State=IDLE(0), Done=0, Count=0, RdData=0.
- Write pointer, decimation counter and start address cleared.
- Edge-detect history registers for Arm, ExtTrig and ForceTrig set to 1, so inputs held high through reset never produce an edge.
- RAM contents are not cleared.

Edge detection:
- Edge = current input & ~registered previous value.
- Trigger = ExtTrig edge OR ForceTrig edge.
- Edges are acted on in the same cycle; triggers arriving in any state other than WAIT_TRIG are discarded, not remembered.

Decimation strobe:
- Counter runs 0..Decim; strobe is asserted on the cycle the counter equals Decim, after which the counter returns to 0.
- Decim=0 gives a strobe every cycle.
- Counter is cleared on an Arm edge.
- Each strobe in PREFILL, WAIT_TRIG or POST writes InData to mem[wr_ptr], then wr_ptr increments modulo DEPTH.

FSM:
- IDLE(0): no writes. An Arm edge goes to PREFILL.
- PREFILL(1):
  - Counts strobes.
  - When the count reaches PreTrig, go to WAIT_TRIG.
  - PreTrig=0 goes to WAIT_TRIG on the first cycle with no write.
- WAIT_TRIG(2):
  - Keeps writing, wrapping circularly.
  - On a trigger, go to POST next cycle. A sample strobed on the trigger cycle is written and counts as pre-trigger.
  - On POST entry, start_addr = (wr_ptr − PreTrig) mod DEPTH.
- POST(3):
  - Each strobe increments Count.
  - When Count reaches DEPTH − PreTrig, go to DONE.
- DONE(4): no writes; Done=1. Only an Arm edge leaves this state.

Arm edge in any state (including mid-PREFILL, WAIT_TRIG, POST or DONE):
- Go to PREFILL and clear wr_ptr, Count and Done.
- Arm takes priority over a coincident trigger.

Readback:
- RdData = mem[(start_addr + RdAddr) mod DEPTH].
- Latency is 2 Clk from RdAddr (registered address plus registered RAM output).
- Reads are valid only in DONE; in other states the value is undefined but stable.

Width rules:
- Pointer arithmetic is modulo DEPTH.
- Samples are stored bit-exact; no scaling or saturation.
- PreTrig values above DEPTH-1 are impossible by width.

Mid-capture events:
- Reset mid-capture returns to IDLE immediately.
- A PreTrig or Decim change mid-capture takes effect on the next comparison; that capture's contents are unspecified.

Test Plan:
1. Hold Arm=1 and ExtTrig=1 through reset, release Reset -> State stays 0, Done=0, no RAM writes.
2. DEPTH_LOG2=4, Decim=0, PreTrig=4, InData = ramp +1/clk, Arm edge, ExtTrig rises on the cycle InData=100 -> Done=1 after 12 post samples, Count=12; RdAddr 0..15 returns 97..112, each 2 cycles after the address.
3. Same as scenario 2 but PreTrig=0 -> RdAddr 0 returns 101, RdAddr 15 returns 116.
4. Decim=3, PreTrig=4, ForceTrig rise -> adjacent RdAddr values differ by exactly 4; Count increments every 4th clock.
5. ExtTrig pulses during PREFILL -> ignored, State stays 1 then 2; a later pulse triggers normally.
6. Arm edge during POST (Count=5) -> State=1, Count=0, Done=0, capture completes afresh. Separately, Reset=0 during POST -> State=0, Done=0, RdData=0 on the next cycle.
